// File: rtl/db15_pkg.sv
// db15_pkg: shared frame constants, bit layout and FSM state type for the DB15 joystick link
package db15_pkg;
    localparam int FRAME_BITS_DEF = 24;
    localparam int JOY_W          = 12;
    localparam int P1_LSB         = 0;
    localparam int P2_LSB         = JOY_W;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} db15_state_t;
endpackage

// File: rtl/db15_sync.sv
// db15_sync: multi-flop synchronizer with toggle detection on the synchronized level
module db15_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_edge
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    // shift the pin through the chain and remember the last synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{INIT}};
            r_prev <= INIT;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
            r_prev <= r_sync[STAGES-1];
        end
    end
    assign o_q    = r_sync[STAGES-1];
    assign o_edge = r_sync[STAGES-1] ^ r_prev;
endmodule

// File: rtl/db15_joy_tx.sv
// db15_joy_tx: serializes two 12-button joysticks onto an active-low shift-register style link
module db15_joy_tx
    import db15_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1048575
)(
    input  logic        clk,
    input  logic        RESET_L,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    input  logic        joy_load,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        frame_done,
    output logic        overrun,
    output logic        link_active,
    output logic [7:0]  frame_cnt
);
    localparam int             CW       = $clog2(FRAME_BITS + 1);
    localparam int             IW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT);

    db15_state_t           r_state, w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift, w_shift_nxt, w_load_val;
    logic [CW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [IW-1:0]         r_idle;
    logic [7:0]            r_frame_cnt;
    logic                  r_data, r_done, r_overrun, r_link;
    logic                  w_ld, w_ld_edge, w_ck, w_ck_edge;
    logic                  w_ld_fall, w_ld_rise, w_ck_rise, w_idle_sat;
    logic                  w_frame_end, w_extra;

    db15_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_load (
        .clk(clk), .rst_n(RESET_L), .i_d(joy_load), .o_q(w_ld), .o_edge(w_ld_edge)
    );
    db15_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_clk (
        .clk(clk), .rst_n(RESET_L), .i_d(joy_clk), .o_q(w_ck), .o_edge(w_ck_edge)
    );

    assign w_ld_fall  = w_ld_edge & ~w_ld;
    assign w_ld_rise  = w_ld_edge & w_ld;
    assign w_ck_rise  = w_ck_edge & w_ck & w_ld;
    assign w_idle_sat = (r_idle == IDLE_MAX);

    // next state: load low wins, then idle timeout, then per-state shifting
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_frame_end   = 1'b0;
        w_extra       = 1'b0;
        w_load_val    = '1;
        w_load_val[P1_LSB +: JOY_W] = ~joystick1;
        w_load_val[P2_LSB +: JOY_W] = ~joystick2;
        if (w_ld_fall || (r_state != ST_IDLE && !w_ld && !w_idle_sat)) begin
            w_state_nxt   = ST_LOAD;
            w_bit_cnt_nxt = '0;
        end else if (w_idle_sat) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '1;
        end else begin
            case (r_state)
                ST_LOAD:  if (w_ld_rise) w_state_nxt = ST_SHIFT;
                ST_SHIFT: if (w_ck_rise) begin
                    w_shift_nxt   = {1'b1, r_shift[FRAME_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_frame_end   = (r_bit_cnt == LAST_BIT);
                    w_state_nxt   = w_frame_end ? ST_DONE : ST_SHIFT;
                end
                ST_DONE:  w_extra = w_ck_rise;
                default:  w_state_nxt = r_state;
            endcase
        end
        if (w_state_nxt == ST_LOAD && !w_ld) w_shift_nxt = w_load_val;
    end

    // frame state, serial data and status registers
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state     <= ST_IDLE;
            r_shift     <= '1;
            r_bit_cnt   <= '0;
            r_data      <= 1'b1;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_data      <= (w_state_nxt == ST_SHIFT) ? w_shift_nxt[0] : 1'b1;
            r_done      <= w_frame_end;
            r_overrun   <= r_overrun | w_extra;
            r_frame_cnt <= r_frame_cnt + {7'd0, w_frame_end};
        end
    end

    // idle watchdog: restarted by each load falling edge, saturates at TIMEOUT
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_idle <= '0;
            r_link <= 1'b0;
        end else begin
            r_idle <= w_ld_fall ? '0 : (w_idle_sat ? r_idle : r_idle + 1'b1);
            r_link <= w_ld_fall ? 1'b1 : (w_idle_sat ? 1'b0 : r_link);
        end
    end

    assign joy_data    = r_data;
    assign frame_done  = r_done;
    assign overrun     = r_overrun;
    assign link_active = r_link;
    assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_db15_joy_tx.sv
// tb_db15_joy_tx: directed and randomized frames against a bit-level reference of the link protocol
module tb_db15_joy_tx;
    localparam int FB = 24;
    localparam int SS = 2;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        RESET_L = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_clk = 1'b0;
    logic [11:0] joystick1 = '0;
    logic [11:0] joystick2 = '0;
    logic        joy_data, frame_done, overrun, link_active;
    logic [7:0]  frame_cnt;

    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   m_frames = 0;
    logic m_ovr = 1'b0;

    db15_joy_tx #(.FRAME_BITS(FB), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .RESET_L(RESET_L), .joystick1(joystick1), .joystick2(joystick2),
        .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data),
        .frame_done(frame_done), .overrun(overrun), .link_active(link_active),
        .frame_cnt(frame_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] a, input logic [11:0] b);
        joystick1 = a;
        joystick2 = b;
        joy_load  = 1'b0;
        cycles(4);
        joy_load  = 1'b1;
        cycles(SS + 3);
    endtask

    task automatic pulse();
        joy_clk = 1'b1;
        cycles(3);
        joy_clk = 1'b0;
        cycles(3);
    endtask

    task automatic frame(input logic [11:0] a, input logic [11:0] b, input int n, input string tag);
        logic [23:0] word;
        int          d0;
        word = ~{b, a};
        d0   = done_seen;
        load(a, b);
        check({tag, " link"}, link_active, 1);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s bit%0d", tag, k), joy_data, (k < FB) ? word[k] : 1'b1);
            pulse();
            if (k == 5) begin
                joystick1 = 12'($urandom);
                joystick2 = 12'($urandom);
            end
        end
        cycles(2);
        if (n >= FB) m_frames++;
        if (n > FB) m_ovr = 1'b1;
        check({tag, " done_count"}, done_seen - d0, (n >= FB) ? 1 : 0);
        check({tag, " frame_cnt"}, frame_cnt, m_frames % 256);
        check({tag, " overrun"}, overrun, m_ovr);
    endtask

    initial begin
        int d0;
        cycles(3);
        check("rst joy_data", joy_data, 1);
        check("rst frame_done", frame_done, 0);
        check("rst overrun", overrun, 0);
        check("rst link", link_active, 0);
        check("rst frame_cnt", frame_cnt, 0);
        RESET_L = 1'b1;
        cycles(5);
        check("post-rst link", link_active, 0);
        check("post-rst joy_data", joy_data, 1);

        frame(12'h001, 12'h000, FB, "p1_r");
        frame(12'h000, 12'h800, FB, "p2_top");
        for (int i = 0; i < 4; i++) frame(12'($urandom), 12'($urandom), FB, $sformatf("rand%0d", i));

        d0 = done_seen;
        load(12'($urandom), 12'($urandom));
        for (int k = 0; k < 10; k++) pulse();
        joy_load = 1'b0;
        cycles(6);
        check("abort done_count", done_seen - d0, 0);
        check("abort frame_cnt", frame_cnt, m_frames % 256);
        check("abort joy_data", joy_data, 1);
        frame(12'($urandom), 12'($urandom), FB, "after_abort");

        frame(12'($urandom), 12'($urandom), FB + 2, "overrun");
        frame(12'($urandom), 12'($urandom), FB, "after_overrun");

        load(12'h001, 12'h000);
        cycles(880);
        check("pre-timeout link", link_active, 1);
        check("pre-timeout joy_data", joy_data, 0);
        cycles(125);
        check("timeout link", link_active, 0);
        check("timeout joy_data", joy_data, 1);
        joy_load = 1'b0;
        cycles(5);
        check("relink link", link_active, 1);
        frame(12'($urandom), 12'($urandom), FB, "after_timeout");

        load(12'h0F0, 12'h00F);
        for (int k = 0; k < 7; k++) pulse();
        joy_clk = 1'b1;
        #3 RESET_L = 1'b0;
        #2;
        check("async rst joy_data", joy_data, 1);
        check("async rst frame_done", frame_done, 0);
        check("async rst overrun", overrun, 0);
        check("async rst link", link_active, 0);
        check("async rst frame_cnt", frame_cnt, 0);
        joy_clk  = 1'b0;
        m_frames = 0;
        m_ovr    = 1'b0;
        cycles(3);
        RESET_L = 1'b1;
        cycles(3);
        for (int i = 0; i < 256; i++) frame(12'($urandom), 12'($urandom), FB, $sformatf("wrap%0d", i));
        check("wrap frame_cnt zero", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
